// File: rtl/icu_sequencer.sv
// icu_sequencer: program counter, return stack and I/O latch bank sitting
// between an asynchronous-read program memory and a 1-bit ICU core.
// Every word is presented in address order; JMP/RTN redirect pc on the
// same edge the ICU executes them, so targets appear with no bubble.
module icu_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int IO_W        = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDR_W-1:0]            pm_addr_o,
  input  logic [ADDR_W+3:0]            pm_data_i,
  output logic [3:0]                   instr_o,
  output logic                         data_in_o,
  input  logic                         write_i,
  input  logic                         data_out_i,
  input  logic [(2**IO_W)-1:0]         in_bus_i,
  output logic [(2**IO_W)-1:0]         out_bus_o,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [$clog2(STACK_DEPTH):0] sp_o,
  output logic                         err_o
);

  localparam int N_IO  = 2 ** IO_W;
  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_RTN = 4'hD;

  // Fields of the word currently addressed by pc
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [IO_W-1:0]   io_addr;

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [IO_W-1:0]   addr_q;
  logic [N_IO-1:0]   out_q, out_d;

  // Return stack storage; entries above sp are don't-care, so no reset
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push;
  logic              stack_full;
  logic              stack_empty;
  logic [ADDR_W-1:0] pc_inc;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;

  assign opcode   = pm_data_i[ADDR_W+3:ADDR_W];
  assign operand  = pm_data_i[ADDR_W-1:0];
  assign io_addr  = operand[IO_W-1:0];

  assign pm_addr_o = pc_q;
  assign pc_o      = pc_q;
  assign sp_o      = sp_q;
  assign err_o     = err_q;
  assign out_bus_o = out_q;
  assign instr_o   = opcode;
  assign data_in_o = in_bus_i[io_addr];

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign sp_dec      = sp_q - SP_W'(1);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign push_idx    = sp_q[IDX_W-1:0];
  assign top_idx     = sp_dec[IDX_W-1:0];

  // Next pc / stack pointer / error flag from the word being executed
  always_comb begin
    pc_d  = pc_inc;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    case (opcode)
      OP_JMP: begin
        // The jump is always taken; a full stack just loses the return address
        pc_d = operand;
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
        end
      end
      OP_RTN: begin
        // Underflow restarts the program from address 0
        if (stack_empty) begin
          pc_d  = '0;
          err_d = 1'b1;
        end else begin
          pc_d = stack_q[top_idx];
          sp_d = sp_dec;
        end
      end
      default: ;
    endcase
  end

  // Output latches: write strobe belongs to the previous edge's instruction
  generate
    for (genvar gi = 0; gi < N_IO; gi++) begin : g_out_bit
      assign out_d[gi] = (write_i && (addr_q == IO_W'(gi))) ? data_out_i : out_q[gi];
    end
  endgenerate

  // Sequencer state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      sp_q   <= '0;
      err_q  <= 1'b0;
      addr_q <= '0;
      out_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      err_q  <= err_d;
      addr_q <= io_addr;
      out_q  <= out_d;
    end
  end

  // Return-address write on a successful push
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_icu_sequencer.sv
// Self-checking bench for icu_sequencer: directed programs from the test
// plan plus random ROM runs, all checked against a queue-based model.
module tb_icu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pm_addr_s;
  logic [11:0] pm_data_s;
  logic [3:0]  instr_s;
  logic        data_in_s;
  logic        write_s;
  logic        data_out_s;
  logic [7:0]  in_bus_s;
  logic [7:0]  out_bus_s;
  logic [7:0]  pc_s;
  logic [2:0]  sp_s;
  logic        err_s;

  logic [11:0] rom [256];

  int tests_run;
  int tests_failed;

  // Behavioural model state
  logic [7:0] m_pc;
  logic [7:0] m_stk [$];
  logic       m_err;
  logic [2:0] m_addr;
  logic [7:0] m_out;

  icu_sequencer #(.ADDR_W(8), .IO_W(3), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pm_addr_o  (pm_addr_s),
    .pm_data_i  (pm_data_s),
    .instr_o    (instr_s),
    .data_in_o  (data_in_s),
    .write_i    (write_s),
    .data_out_i (data_out_s),
    .in_bus_i   (in_bus_s),
    .out_bus_o  (out_bus_s),
    .pc_o       (pc_s),
    .sp_o       (sp_s),
    .err_o      (err_s)
  );

  assign pm_data_s = rom[pm_addr_s];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fill ROM with random non-flow opcodes
  task automatic fill_linear();
    logic [3:0] op;
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom_range(0, 11));
      rom[i] = {op, 8'(i)};
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
  endtask

  task automatic model_reset();
    m_pc   = 8'h00;
    m_stk  = {};
    m_err  = 1'b0;
    m_addr = 3'd0;
    m_out  = 8'h00;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".pc"},  32'(pc_s),      32'(m_pc));
    check_eq({tag, ".sp"},  32'(sp_s),      32'(m_stk.size()));
    check_eq({tag, ".err"}, 32'(err_s),     32'(m_err));
    check_eq({tag, ".out"}, 32'(out_bus_s), 32'(m_out));
  endtask

  // Called between edges: assert reset, check async clear, release later
  task automatic do_reset();
    write_s = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("rst.pc",      32'(pc_s),      32'h0);
    check_eq("rst.pm_addr", 32'(pm_addr_s), 32'h0);
    check_eq("rst.sp",      32'(sp_s),      32'h0);
    check_eq("rst.err",     32'(err_s),     32'h0);
    check_eq("rst.out",     32'(out_bus_s), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check combinational outputs, apply edge, check state
  task automatic step(input logic [7:0] bus, input logic wr, input logic dout);
    logic [11:0] w;
    logic [3:0]  op;
    logic [7:0]  opr;
    in_bus_s   = bus;
    write_s    = wr;
    data_out_s = dout;
    #1;
    w   = rom[m_pc];
    op  = w[11:8];
    opr = w[7:0];
    check_eq("pm_addr", 32'(pm_addr_s), 32'(m_pc));
    check_eq("instr",   32'(instr_s),   32'(op));
    check_eq("data_in", 32'(data_in_s), 32'(bus[opr[2:0]]));
    if (wr) m_out[m_addr] = dout;
    m_addr = opr[2:0];
    if (op == 4'hC) begin
      if (m_stk.size() < 4) m_stk.push_back(m_pc + 8'd1);
      else m_err = 1'b1;
      m_pc = opr;
    end else if (op == 4'hD) begin
      if (m_stk.size() == 0) begin
        m_pc  = 8'h00;
        m_err = 1'b1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else begin
      m_pc = m_pc + 8'd1;
    end
    @(posedge clk);
    #1;
    $display("[TB] exec op=%h opr=%02h wr=%0d -> pc=%02h sp=%0d err=%0d out=%02h",
             op, opr, wr, pc_s, sp_s, err_s, out_bus_s);
    check_state("step");
  endtask

  task automatic step_rand();
    step(8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    write_s      = 1'b0;
    data_out_s   = 1'b0;
    in_bus_s     = 8'h00;
    model_reset();
    fill_linear();
    #1;

    // Sequential program, including wrap from 0xFF to 0x00
    do_reset();
    for (int i = 0; i < 258; i++) begin
      step_rand();
      if (i == 254) check_eq("wrap.pc_ff", 32'(pc_s), 32'hFF);
      if (i == 255) check_eq("wrap.pc_00", 32'(pc_s), 32'h00);
    end

    // Single JMP / RTN
    fill_linear();
    rom[8'h00] = {4'hC, 8'h10};
    rom[8'h10] = {4'hD, 8'h5A};
    do_reset();
    step(8'h00, 1'b0, 1'b0);
    check_eq("jmp.pc", 32'(pc_s), 32'h10);
    check_eq("jmp.sp", 32'(sp_s), 32'd1);
    step(8'h00, 1'b0, 1'b0);
    check_eq("rtn.pc",  32'(pc_s),  32'h01);
    check_eq("rtn.sp",  32'(sp_s),  32'd0);
    check_eq("rtn.err", 32'(err_s), 32'd0);

    // Five nested JMPs, then RTN chain through the four stored returns
    fill_linear();
    rom[8'h00] = {4'hC, 8'h20};
    rom[8'h20] = {4'hC, 8'h30};
    rom[8'h30] = {4'hC, 8'h40};
    rom[8'h40] = {4'hC, 8'h50};
    rom[8'h50] = {4'hC, 8'h60};
    rom[8'h60] = {4'hD, 8'h00};
    rom[8'h41] = {4'hD, 8'h00};
    rom[8'h31] = {4'hD, 8'h00};
    rom[8'h21] = {4'hD, 8'h00};
    rom[8'h01] = {4'hD, 8'h00};
    do_reset();
    for (int i = 0; i < 5; i++) step_rand();
    check_eq("nest.sp",  32'(sp_s),  32'd4);
    check_eq("nest.err", 32'(err_s), 32'd1);
    check_eq("nest.pc",  32'(pc_s),  32'h60);
    step_rand();
    check_eq("nest.ret1", 32'(pc_s), 32'h41);
    for (int i = 0; i < 3; i++) step_rand();
    check_eq("nest.ret4", 32'(pc_s), 32'h01);
    check_eq("nest.sp0",  32'(sp_s), 32'd0);
    step_rand();
    check_eq("nest.under", 32'(pc_s), 32'h00);

    // Self-jump with a full stack holds pc
    fill_linear();
    rom[8'h00] = {4'hC, 8'h01};
    rom[8'h01] = {4'hC, 8'h02};
    rom[8'h02] = {4'hC, 8'h03};
    rom[8'h03] = {4'hC, 8'h04};
    rom[8'h04] = {4'hC, 8'h04};
    do_reset();
    for (int i = 0; i < 7; i++) step_rand();
    check_eq("self.pc",  32'(pc_s),  32'h04);
    check_eq("self.sp",  32'(sp_s),  32'd4);
    check_eq("self.err", 32'(err_s), 32'd1);

    // Input selection: LD 2 then LD 3 with in_bus = 0000_0100
    fill_linear();
    rom[8'h00] = {4'h1, 8'h02};
    rom[8'h01] = {4'h1, 8'h03};
    do_reset();
    in_bus_s = 8'b0000_0100;
    #1;
    check_eq("in.op2", 32'(data_in_s), 32'd1);
    step(8'b0000_0100, 1'b0, 1'b0);
    check_eq("in.op3", 32'(data_in_s), 32'd0);

    // STO 5, write strobe next cycle, then JMPs to sp=2, then async reset
    fill_linear();
    rom[8'h00] = {4'h8, 8'h05};
    rom[8'h01] = {4'hC, 8'h10};
    rom[8'h10] = {4'hC, 8'h20};
    do_reset();
    step(8'h00, 1'b0, 1'b0);
    check_eq("sto.before", 32'(out_bus_s), 32'h00);
    step(8'h00, 1'b1, 1'b1);
    check_eq("sto.after", 32'(out_bus_s), 32'h20);
    step(8'h00, 1'b0, 1'b0);
    check_eq("mid.sp", 32'(sp_s), 32'd2);
    do_reset();

    // Random programs with occasional mid-run reset
    for (int r = 0; r < 3; r++) begin
      fill_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
        step_rand();
        if (i == 250) do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
